// File: rtl/hscale_madd_feeder_pkg.sv
// Shared definitions for the upscaler multiply-add feeder: unit opcodes,
// FSM state encoding and the default issue-to-result latency.
package hscale_madd_feeder_pkg;

  localparam logic [1:0] INOP_NOP         = 2'b00;
  localparam logic [1:0] INOP_FIR_SHIFT   = 2'b10;
  localparam logic [1:0] CALCOP_NORMAL    = 2'b00;
  localparam logic [1:0] CALCOP_BYPASS_A1 = 2'b10;

  localparam int MADD_LATENCY_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/hscale_madd_feeder_valid_delay_line.sv
// Shift register that delays the issue strobe to line up with the unit's
// result; a synchronous clear flushes strobes of an aborted line.
module hscale_madd_feeder_valid_delay_line
  import hscale_madd_feeder_pkg::*;
#(
  parameter int DEPTH = MADD_LATENCY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din,
  output logic [DEPTH-1:0] taps,
  output logic             dout
);

  logic [DEPTH-1:0] vld_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (clr) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign taps = vld_p;
  assign dout = vld_p[DEPTH-1];

endmodule

// File: rtl/hscale_madd_feeder.sv
// Operand sequencer for the two-tap multiply-add unit of the horizontal
// linear-interpolation upscaler: primes the taps, steps the phase, issues.
module hscale_madd_feeder
  import hscale_madd_feeder_pkg::*;
#(
  parameter int PIX_W        = 8,
  parameter int WEIGHT_W     = 8,
  parameter int CNT_W        = 11,
  parameter int MADD_LATENCY = MADD_LATENCY_DEF
) (
  input  logic                CLK_i,
  input  logic                nRST_i,
  input  logic                line_start_i,
  input  logic [CNT_W-1:0]    out_len_i,
  input  logic [WEIGHT_W:0]   inc_i,
  input  logic [PIX_W-1:0]    src_data_i,
  input  logic                src_valid_i,
  input  logic                src_last_i,
  output logic                src_ready_o,
  output logic [1:0]          inopcode_o,
  output logic [1:0]          calcopcode_o,
  output logic [PIX_W-1:0]    data_a0_o,
  output logic [WEIGHT_W-1:0] data_b0_o,
  output logic [WEIGHT_W-1:0] data_b1_o,
  output logic                out_valid_o,
  output logic                busy_o,
  output logic                line_done_o
);

  localparam int PH_W = WEIGHT_W + 1;
  localparam logic [PH_W-1:0] UNITY = {1'b1, {WEIGHT_W{1'b0}}};

  function automatic logic [CNT_W-1:0] norm_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

  // Increments outside 1..256 collapse to 1:1 so at most one shift is needed per emission.
  function automatic logic [PH_W-1:0] norm_inc(input logic [PH_W-1:0] inc);
    return (inc == '0 || inc > UNITY) ? UNITY : inc;
  endfunction

  function automatic logic [WEIGHT_W-1:0] weight_complement(input logic [WEIGHT_W-1:0] f);
    return WEIGHT_W'(UNITY - PH_W'(f));
  endfunction

  state_t               state;
  logic [CNT_W-1:0]     len_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [PH_W-1:0]      inc_q;
  logic [WEIGHT_W-1:0]  frac_q;
  logic                 need_shift_q;
  logic                 last_seen_q;
  logic                 prime_cnt_q;
  logic [PIX_W-1:0]     last_pix_q;
  logic                 issue_q;
  logic [MADD_LATENCY-1:0] vld_taps;

  logic                 take;
  logic                 pix_avail;
  logic [PIX_W-1:0]     cur_pix;
  logic [PH_W-1:0]      phase_sum;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 emit;
  logic                 pending;

  // Once the last beat is in, every later shift replicates it without waiting.
  assign src_ready_o = !last_seen_q &&
                       ((state == ST_PRIME) || (state == ST_DRAIN) ||
                        (state == ST_RUN && need_shift_q));
  assign take      = src_valid_i && src_ready_o;
  assign pix_avail = last_seen_q || src_valid_i;
  assign cur_pix   = last_seen_q ? last_pix_q : src_data_i;
  assign phase_sum = PH_W'(frac_q) + inc_q;
  assign cnt_nxt   = cnt_q + CNT_W'(1);
  assign emit      = (state == ST_RUN) && (!need_shift_q || pix_avail);
  assign pending   = issue_q || (|vld_taps);
  assign busy_o    = (state != ST_IDLE);

  always_ff @(posedge CLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      inc_q        <= '0;
      frac_q       <= '0;
      need_shift_q <= 1'b0;
      last_seen_q  <= 1'b0;
      prime_cnt_q  <= 1'b0;
      last_pix_q   <= '0;
      issue_q      <= 1'b0;
      inopcode_o   <= INOP_NOP;
      calcopcode_o <= CALCOP_NORMAL;
      data_a0_o    <= '0;
      data_b0_o    <= '0;
      data_b1_o    <= '0;
      line_done_o  <= 1'b0;
    end else begin
      inopcode_o   <= INOP_NOP;
      calcopcode_o <= CALCOP_NORMAL;
      issue_q      <= 1'b0;
      line_done_o  <= 1'b0;

      if (take) begin
        last_pix_q <= src_data_i;
        if (src_last_i) last_seen_q <= 1'b1;
      end

      if (line_start_i) begin
        state        <= ST_PRIME;
        len_q        <= norm_len(out_len_i);
        inc_q        <= norm_inc(inc_i);
        cnt_q        <= '0;
        frac_q       <= '0;
        need_shift_q <= 1'b0;
        last_seen_q  <= 1'b0;
        prime_cnt_q  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: ;

          // Two shifts fill the taps: a1 = P0, a0 = P1.
          ST_PRIME: begin
            if (pix_avail) begin
              inopcode_o  <= INOP_FIR_SHIFT;
              data_a0_o   <= cur_pix;
              prime_cnt_q <= 1'b1;
              if (prime_cnt_q) begin
                state        <= ST_RUN;
                frac_q       <= '0;
                need_shift_q <= 1'b0;
                cnt_q        <= '0;
              end
            end
          end

          ST_RUN: begin
            if (emit) begin
              inopcode_o   <= need_shift_q ? INOP_FIR_SHIFT : INOP_NOP;
              if (need_shift_q) data_a0_o <= cur_pix;
              data_b0_o    <= frac_q;
              data_b1_o    <= weight_complement(frac_q);
              calcopcode_o <= (frac_q == '0) ? CALCOP_BYPASS_A1 : CALCOP_NORMAL;
              issue_q      <= 1'b1;
              frac_q       <= phase_sum[WEIGHT_W-1:0];
              need_shift_q <= phase_sum[WEIGHT_W];
              cnt_q        <= cnt_nxt;
              if (cnt_nxt == len_q) state <= ST_DRAIN;
            end
          end

          ST_DRAIN: begin
            if (last_seen_q && !pending) begin
              line_done_o <= 1'b1;
              state       <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  hscale_madd_feeder_valid_delay_line #(
    .DEPTH (MADD_LATENCY)
  ) u_vld_dly (
    .clk   (CLK_i),
    .rst_n (nRST_i),
    .clr   (line_start_i),
    .din   (issue_q),
    .taps  (vld_taps),
    .dout  (out_valid_o)
  );

endmodule

// File: doc/hscale_madd_feeder.md
Name: hscale_madd_feeder

Overview:
- Operand sequencer and initiator for the two-tap multiply-add unit in the horizontal linear-interpolation upscaler.
- Pulls one source line as a valid/ready pixel stream and steps a fixed-point phase accumulator.
- Drives the unit's opcode, pixel (a0) and weight (b0/b1) inputs using its FIR-shift mode.
- Delays an issue strobe to match the unit's latency, so the downstream line writer gets out_valid_o aligned with result_data.

Parameters:
- PIX_W, 8, source pixel width; equals the unit's INPUT_DATA_A_W.
- WEIGHT_W, 8, fractional phase bits; equals the unit's INPUT_DATA_B_W.
- CNT_W, 11, output column counter width.
- MADD_LATENCY, 3, issue-to-result latency of the multiply-add unit (3 + its POST_REGS).

Ports:
- CLK_i  in  1  system clock.
- nRST_i  in  1  asynchronous active-low reset.
- line_start_i  in  1  one-cycle pulse; latches out_len_i and inc_i and starts a line.
- out_len_i  in  CNT_W  number of output pixels for the line (0 is treated as 1).
- inc_i  in  WEIGHT_W+1  phase increment per output pixel, 1..256 (256 = 1:1; 0 is treated as 256).
- src_data_i  in  PIX_W  source pixel.
- src_valid_i  in  1  source pixel valid.
- src_last_i  in  1  marks the last source pixel of the line.
- src_ready_o  out  1  pixel is consumed when src_valid_i and src_ready_o are both high.
- inopcode_o  out  2  to the unit: 00 nop, 10 fir shift (01 and 11 are never driven).
- calcopcode_o  out  2  to the unit: 00 normal, 10 bypass a1.
- data_a0_o  out  PIX_W  pixel shifted into the unit.
- data_b0_o  out  WEIGHT_W  weight on the newer tap (a0).
- data_b1_o  out  WEIGHT_W  weight on the older tap (a1).
- out_valid_o  out  1  high when the unit's result_data is a valid output pixel.
- busy_o  out  1  high in any state other than IDLE.
- line_done_o  out  1  one-cycle pulse at end of line.

Behaviour:
- Reset: all outputs 0; state IDLE; phase 0; issue delay line cleared.
- States: IDLE, PRIME, RUN, DRAIN.
- IDLE -> PRIME on line_start_i.
- PRIME loads two pixels, issuing inop 10 with calcop 00 and no issue strobe per consumed pixel.
  - After two loads: set a1 = P0, a0 = P1, frac f = 0, and go to RUN.
- RUN, one emission per cycle when possible; each emission is one issue:
  - Drive b0 = f and b1 = (256 - f) mod 256.
  - Drive calcop 10 (bypass a1) when f == 0, else calcop 00.
  - Result equals (f·a0 + (256 - f)·a1) / 256, i.e. the top PIX_W bits.
  - Then compute s = f + inc. If s >= 256, the next emission is preceded in the same issue by a shift: inop 10 with a0 = next pixel. Otherwise inop 00. New f = s[WEIGHT_W-1:0].
  - A shift needs a source pixel. If src_valid_i is low: inop 00, no issue strobe, and phase and counter are held (stall).
- Past end of source: once the src_last_i beat has been consumed, src_ready_o goes low. Later shifts replicate the last pixel without waiting. This also covers a 1-pixel line during PRIME.
- Output counter:
  - Increments on each issued emission.
  - When it reaches out_len, go to DRAIN.
  - No further inop 10 is issued after the final emission.
- DRAIN:
  - src_ready_o = 1 and source beats are discarded until src_last_i has been seen.
  - line_done_o pulses once src_last_i has been seen and the delay line is empty (no issue strobe still in flight). Then go to IDLE.
- out_valid_o is the issue strobe delayed by MADD_LATENCY registers.
- line_start_i in PRIME, RUN or DRAIN aborts the current line:
  - Clear the delay line so no stale out_valid_o appears.
  - Drop source state and go to PRIME with the new parameters.
  - No line_done_o for the aborted line.
- busy_o = state != IDLE.
- Simultaneous stall and final emission: the final emission waits for its pixel like any other.

Decomposition:
- Shared package:
  - inop_* and calcop_* opcode constants (shared with the multiply-add unit).
  - State encoding.
  - Default MADD_LATENCY.
- One natural sub-module: valid_delay_line (parameterised depth, synchronous clear) for the issue-to-out_valid alignment.

Test Plan:
- inc=128, out_len=8, pixels 10,20,30,40 (last on 40) -> result sequence 10,15,20,25,30,35,40,40. Calcop is bypass on emissions 0,2,4,6. One line_done_o pulse.
- inc=256, out_len=4, pixels 10,20,30,40 -> results 10,20,30,40. Every emission uses bypass, and a shift precedes emissions 1-3.
- Same as test 1 with src_valid_i low for 3 cycles before pixel 30 -> identical result sequence, and out_valid_o shows a 3-cycle gap.
- inc=64, out_len=4, pixels 0,100 -> results 0,25,50,75. Weight pairs (b0,b1) = (0,0 bypass),(64,192),(128,128),(192,64).
- line_start_i mid-RUN (after 3 emissions), then a fresh 1:1 line -> no out_valid_o from the first line after the restart, second-line results correct, exactly one line_done_o.
- nRST_i asserted mid-RUN -> all outputs 0 immediately. After release the block is IDLE and the next line runs correctly.
